// File: rtl/exc_arbiter.sv
// ---------------------------------------------------------------------------
// exc_arbiter
//   Collects NUM_SRC exception request channels into sticky pending latches.
//   Each latch keeps the first cause code seen while it is pending. One
//   fixed-priority winner (lowest index) is presented at a time to the
//   exception sequencer over a req/ack handshake. Overruns are flagged.
//
// Ports
//   clk       : clock, all state updates on posedge
//   rst       : synchronous active-low reset
//   src_req   : per-channel request, bit i = channel i
//   src_code  : channel i cause code at [i*CODE_W +: CODE_W]
//   src_mask  : (EXC_MASK_EN only) per-channel eligibility mask
//   ack       : sequencer accepted the presented exception
//   exc_req   : an exception is presented
//   exc_idx   : index of the presented channel
//   exc_code  : captured code of the presented channel
//   pend      : current pending latches
//   lost      : sticky overrun flag
//
// Optional feature: define EXC_MASK_EN to add the src_mask input.
// ---------------------------------------------------------------------------
module exc_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int CODE_W  = 3,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC*CODE_W-1:0] src_code,
`ifdef EXC_MASK_EN
  input  logic [NUM_SRC-1:0]        src_mask,
`endif
  input  logic                      ack,
  output logic                      exc_req,
  output logic [IDX_W-1:0]          exc_idx,
  output logic [CODE_W-1:0]         exc_code,
  output logic [NUM_SRC-1:0]        pend,
  output logic                      lost
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [NUM_SRC-1:0]               pend_q, pend_d;
  logic [NUM_SRC-1:0][CODE_W-1:0]   code_q, code_d;
  logic                             exc_req_q, exc_req_d;
  logic [IDX_W-1:0]                 exc_idx_q, exc_idx_d;
  logic [CODE_W-1:0]                exc_code_q, exc_code_d;
  logic                             lost_q, lost_d;

  logic [NUM_SRC-1:0]               eligible_s;
  logic [NUM_SRC-1:0]               clr_s;
  logic [NUM_SRC-1:0]               overrun_s;
  logic                             ack_cyc_s;
  logic                             win_found_s;
  logic [IDX_W-1:0]                 win_idx_s;
  logic [CODE_W-1:0]                win_code_s;

  // Next-state logic: pending latches, code capture, overrun, winner and FSM
  always_comb begin
`ifdef EXC_MASK_EN
    eligible_s = pend_q & ~src_mask;
`else
    eligible_s = pend_q;
`endif

    // Scan from the top so the lowest eligible index is the last one written.
    win_found_s = 1'b0;
    win_idx_s   = '0;
    win_code_s  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible_s[i]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(i);
        win_code_s  = code_q[i];
      end
    end

    // Only an ack while presenting counts; stray acks are ignored.
    ack_cyc_s = (state_q == ST_PRESENT) && ack;

    clr_s     = '0;
    overrun_s = '0;
    code_d    = code_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_s[i]     = ack_cyc_s && (exc_idx_q == IDX_W'(i));
      overrun_s[i] = src_req[i] && pend_q[i] && !clr_s[i];
      // A request in the ack cycle of its own channel re-arms with the new code.
      if (src_req[i] && (!pend_q[i] || clr_s[i])) begin
        code_d[i] = src_code[i*CODE_W +: CODE_W];
      end else begin
        code_d[i] = code_q[i];
      end
    end

    pend_d = (pend_q & ~clr_s) | src_req;

    // A new overrun takes precedence over the clear carried by an ack.
    if (|overrun_s) begin
      lost_d = 1'b1;
    end else if (ack_cyc_s) begin
      lost_d = 1'b0;
    end else begin
      lost_d = lost_q;
    end

    state_d    = state_q;
    exc_req_d  = exc_req_q;
    exc_idx_d  = exc_idx_q;
    exc_code_d = exc_code_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d    = ST_PRESENT;
          exc_req_d  = 1'b1;
          exc_idx_d  = win_idx_s;
          exc_code_d = win_code_s;
        end else begin
          exc_req_d  = 1'b0;
        end
      end
      ST_PRESENT: begin
        // Winner is held: later higher-priority arrivals do not preempt.
        if (ack) begin
          state_d   = ST_RECOVER;
          exc_req_d = 1'b0;
        end else begin
          exc_req_d = 1'b1;
        end
      end
      ST_RECOVER: begin
        state_d   = ST_IDLE;
        exc_req_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        exc_req_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      code_q     <= '0;
      exc_req_q  <= 1'b0;
      exc_idx_q  <= '0;
      exc_code_q <= '0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      code_q     <= code_d;
      exc_req_q  <= exc_req_d;
      exc_idx_q  <= exc_idx_d;
      exc_code_q <= exc_code_d;
      lost_q     <= lost_d;
    end
  end

  assign exc_req  = exc_req_q;
  assign exc_idx  = exc_idx_q;
  assign exc_code = exc_code_q;
  assign pend     = pend_q;
  assign lost     = lost_q;

endmodule

// File: tb/tb_exc_arbiter.sv
module tb_exc_arbiter;
  localparam int NS = 4;
  localparam int CW = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   src_req;
  logic [NS*CW-1:0] src_code;
  logic [NS-1:0]   src_mask;
  logic            ack;
  logic            exc_req;
  logic [IW-1:0]   exc_idx;
  logic [CW-1:0]   exc_code;
  logic [NS-1:0]   pend;
  logic            lost;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exc_arbiter #(.NUM_SRC(NS), .CODE_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .src_req(src_req), .src_code(src_code),
`ifdef EXC_MASK_EN
    .src_mask(src_mask),
`endif
    .ack(ack), .exc_req(exc_req), .exc_idx(exc_idx), .exc_code(exc_code),
    .pend(pend), .lost(lost)
  );

  // ---------------- reference model (latency-based view) ----------------
  bit m_pend [NS];
  int m_code [NS];
  bit m_lost;
  bit m_show;      // exception currently presented
  int m_idx;
  int m_ocode;
  int m_gap;       // cycles to wait after an ack before re-arbitrating

  function automatic void model_step();
    bit ack_hit;
    int old_idx;
    int win;
    bit ovr;
    if (!rst) begin
      for (int i = 0; i < NS; i++) begin m_pend[i] = 0; m_code[i] = 0; end
      m_lost = 0; m_show = 0; m_idx = 0; m_ocode = 0; m_gap = 0;
      return;
    end
    ack_hit = m_show && ack;
    old_idx = m_idx;
    // presentation decision uses pending state from before this edge
    if (m_show) begin
      if (ack) begin m_show = 0; m_gap = 1; end
    end else if (m_gap > 0) begin
      m_gap = m_gap - 1;
    end else begin
      win = -1;
      for (int i = NS - 1; i >= 0; i--)
        if (m_pend[i] && !src_mask[i]) win = i;
      if (win >= 0) begin m_show = 1; m_idx = win; m_ocode = m_code[win]; end
    end
    ovr = 0;
    for (int i = 0; i < NS; i++) begin
      bit clr;
      clr = ack_hit && (i == old_idx);
      if (src_req[i] && m_pend[i] && !clr) ovr = 1;
      if (src_req[i] && (!m_pend[i] || clr)) m_code[i] = int'(src_code[i*CW +: CW]);
      m_pend[i] = (m_pend[i] && !clr) || src_req[i];
    end
    if (ovr) m_lost = 1;
    else if (ack_hit) m_lost = 0;
  endfunction

  function automatic int model_pend();
    int v = 0;
    for (int i = 0; i < NS; i++) if (m_pend[i]) v = v | (1 << i);
    return v;
  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          r;
    logic [3:0]    req;
    logic [11:0]   code;
    logic          a;
    logic          e_req;
    logic [1:0]    e_idx;
    logic [2:0]    e_code;
    logic [3:0]    e_pend;
    logic          e_lost;
  } vec_t;
  vec_t tbl[$];

  task automatic add(logic r, logic [3:0] req, logic [11:0] code, logic a,
                     logic e_req, logic [1:0] e_idx, logic [2:0] e_code,
                     logic [3:0] e_pend, logic e_lost);
    vec_t v;
    v.r = r; v.req = req; v.code = code; v.a = a; v.e_req = e_req;
    v.e_idx = e_idx; v.e_code = e_code; v.e_pend = e_pend; v.e_lost = e_lost;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b0; src_req = '0; src_code = '0; src_mask = '0; ack = 1'b0;

    // reset with requests asserted, then quiet
    add(0, 4'hF, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    add(0, 4'hF, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    // single request on channel 2, code 5, ack four cycles later
    add(1, 4'h4, 12'h140, 0, 0, 0, 0, 4'h4, 0);
    add(1, 4'h0, 12'h000, 0, 1, 2, 5, 4'h4, 0);
    add(1, 4'h0, 12'h000, 0, 1, 2, 5, 4'h4, 0);
    add(1, 4'h0, 12'h000, 0, 1, 2, 5, 4'h4, 0);
    add(1, 4'h0, 12'h000, 1, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    // idx 3 presented, idx 0 arrives later and must not preempt
    add(1, 4'h8, 12'hC00, 0, 0, 0, 0, 4'h8, 0);
    add(1, 4'h0, 12'h000, 0, 1, 3, 6, 4'h8, 0);
    add(1, 4'h1, 12'h001, 0, 1, 3, 6, 4'h9, 0);
    add(1, 4'h0, 12'h000, 0, 1, 3, 6, 4'h9, 0);
    add(1, 4'h0, 12'h000, 1, 0, 0, 0, 4'h1, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h1, 0);
    add(1, 4'h0, 12'h000, 0, 1, 0, 1, 4'h1, 0);
    add(1, 4'h0, 12'h000, 1, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    // overrun on channel 1: first code kept, lost set, clean ack clears it
    add(1, 4'h2, 12'h010, 0, 0, 0, 0, 4'h2, 0);
    add(1, 4'h2, 12'h038, 0, 1, 1, 2, 4'h2, 1);
    add(1, 4'h0, 12'h000, 1, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    // ack-cycle re-arm on channel 0 with code 3
    add(1, 4'h1, 12'h003, 0, 0, 0, 0, 4'h1, 0);
    add(1, 4'h0, 12'h000, 0, 1, 0, 3, 4'h1, 0);
    add(1, 4'h1, 12'h003, 1, 0, 0, 0, 4'h1, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h1, 0);
    add(1, 4'h0, 12'h000, 0, 1, 0, 3, 4'h1, 0);
    add(1, 4'h0, 12'h000, 1, 0, 0, 0, 4'h0, 0);
    // reset mid-handshake discards the in-flight exception
    add(1, 4'h4, 12'h100, 0, 0, 0, 0, 4'h4, 0);
    add(1, 4'h0, 12'h000, 0, 1, 2, 4, 4'h4, 0);
    add(0, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);
    // overrun on another channel in the ack cycle: set wins over clear
    add(1, 4'h3, 12'h011, 0, 0, 0, 0, 4'h3, 0);
    add(1, 4'h0, 12'h000, 0, 1, 0, 1, 4'h3, 0);
    add(1, 4'h2, 12'h018, 1, 0, 0, 0, 4'h2, 1);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h2, 1);
    add(1, 4'h0, 12'h000, 0, 1, 1, 2, 4'h2, 1);
    add(1, 4'h0, 12'h000, 1, 0, 0, 0, 4'h0, 0);
    // stray ack while idle is ignored
    add(1, 4'h0, 12'h000, 1, 0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 12'h000, 0, 0, 0, 0, 4'h0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].r; src_req = tbl[k].req; src_code = tbl[k].code; ack = tbl[k].a;
      step();
      chk($sformatf("v%0d_exc_req", k), int'(exc_req), int'(tbl[k].e_req));
      chk($sformatf("v%0d_pend", k), int'(pend), int'(tbl[k].e_pend));
      chk($sformatf("v%0d_lost", k), int'(lost), int'(tbl[k].e_lost));
      if (tbl[k].e_req) begin
        chk($sformatf("v%0d_exc_idx", k), int'(exc_idx), int'(tbl[k].e_idx));
        chk($sformatf("v%0d_exc_code", k), int'(exc_code), int'(tbl[k].e_code));
      end
    end

`ifdef EXC_MASK_EN
    // masked channel 0 pending with channel 1: idx 1 goes first
    rst = 1'b1; ack = 1'b0; src_mask = 4'b0001;
    src_req = 4'b0011; src_code = 12'h011;
    step();
    src_req = '0; src_code = '0;
    step();
    chk("mask_first_req", int'(exc_req), 1);
    chk("mask_first_idx", int'(exc_idx), 1);
    chk("mask_first_code", int'(exc_code), 2);
    src_mask = 4'b0000; ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("mask_gap", int'(exc_req), 0);
    step();
    chk("mask_second_req", int'(exc_req), 1);
    chk("mask_second_idx", int'(exc_idx), 0);
    chk("mask_second_code", int'(exc_code), 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    // all pending masked: nothing is presented
    src_mask = 4'b1111; src_req = 4'b0100; src_code = 12'h1C0;
    step();
    src_req = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mask_all_idle", int'(exc_req), 0);
    end
    src_mask = '0;
    step();
    step();
    chk("mask_release_idx", int'(exc_idx), 2);
`endif

    // randomized stimulus against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < NS; i++) src_req[i] = ($urandom_range(0, 5) == 0);
      src_code = NS*CW'($urandom);
      ack = ($urandom_range(0, 2) == 0);
`ifdef EXC_MASK_EN
      src_mask = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
`endif
      step();
      chk("rnd_exc_req", int'(exc_req), int'(m_show));
      chk("rnd_pend", int'(pend), model_pend());
      chk("rnd_lost", int'(lost), int'(m_lost));
      if (m_show) begin
        chk("rnd_exc_idx", int'(exc_idx), m_idx);
        chk("rnd_exc_code", int'(exc_code), m_ocode);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exc_arbiter.md
Name: exc_arbiter

Overview:
- Parametrised successor to the single-source program-error latch.
- Collects NUM_SRC independent exception request channels, each carrying a CODE_W-bit cause code, into per-channel sticky pending latches.
- Presents one fixed-priority winner at a time to the exception/interrupt sequencer over a req/ack handshake, with overrun detection.
- Sits between decode/execute fault detectors and the vectoring logic that loads SRR0/SRR1/ESR.

Parameters:
NUM_SRC, 4, number of request channels; 2..16
CODE_W, 3, width of each channel's cause code
IDX_W, 2, width of winner index; must equal ceil(log2(NUM_SRC))

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-low reset; sampled on posedge clk, state cleared when rst==0
src_req  input  NUM_SRC  per-channel exception request pulse/level, bit i = channel i
src_code  input  NUM_SRC*CODE_W  channel i code at bits [i*CODE_W +: CODE_W]
ack  input  1  sequencer accepted the presented exception
exc_req  output  1  an exception is presented
exc_idx  output  IDX_W  index of presented channel
exc_code  output  CODE_W  captured code of presented channel
pend  output  NUM_SRC  current pending latches
lost  output  1  sticky overrun flag

Behaviour:
- Reset (rst==0 at posedge): pend=0, all captured codes=0, state=IDLE, exc_req=0, exc_idx=0, exc_code=0, lost=0. Applies mid-handshake too; in-flight exception discarded.
- Pending update per channel i each cycle:
  - pend_next[i] = (pend[i] & ~clr[i]) | src_req[i].
  - clr[i] = 1 only in the ack cycle for the presented channel.
- Code capture: code_r[i] <= src_code[i] when src_req[i] and (pend[i]==0 or clr[i]==1); otherwise held. First cause wins while pending.
- Overrun: src_req[i] while pend[i]==1 and clr[i]==0 sets lost=1.
  - lost cleared only by reset, or by an ack cycle with no concurrent overrun.
  - On the same cycle, overrun set wins over the ack clear.
- Priority: lowest index among eligible pending channels wins.
- FSM states:
  - IDLE: exc_req=0. If any eligible pend, latch winner idx/code into exc_idx/exc_code and go to PRESENT.
  - PRESENT: exc_req=1. exc_idx/exc_code held stable; no preemption by higher-priority arrivals. When ack==1, clear pend[exc_idx] and go to RECOVER.
  - RECOVER: exc_req=0 for exactly one cycle, then go to IDLE. IDLE re-evaluates next cycle.
- Latency:
  - src_req at cycle t -> pend visible at t+1 -> exc_req=1 at t+2.
  - ack at cycle a -> exc_req=0 at a+1 and a+2 -> earliest next exc_req=1 at a+3.
- ack while not in PRESENT: ignored, no state change.
- Ack cycle with new src_req on the same channel: pend re-armed with the new code, no overrun.
- exc_idx/exc_code are registers: they hold their last values in IDLE/RECOVER and are valid only while exc_req=1.

Optional Feature:
- Macro EXC_MASK_EN.
- Defined:
  - Adds input src_mask[NUM_SRC]; a channel is eligible only if pend[i] & ~src_mask[i].
  - Masked channels still latch pend, codes and overruns.
  - A mask change during PRESENT does not alter the held winner.
  - With all pending channels masked, the FSM stays in IDLE.
- Undefined: port absent; every pending channel is eligible.

Test Plan:
1. Reset: rst=0 for 2 cycles with src_req=4'b1111 -> pend=0, exc_req=0, lost=0. After rst=1, no exc_req until a new src_req arrives.
2. Single: src_req=4'b0100 with code2=3'b101 at t -> pend=4'b0100 at t+1. exc_req=1, exc_idx=2, exc_code=5 at t+2. ack at t+4 -> pend=0 and exc_req=0 at t+5.
3. Priority/no-preempt: src_req=4'b1000 at t, then 4'b0001 at t+2 while presenting idx 3 -> idx 3 held until ack at a. Idx 0 presented at a+3.
4. Overrun: src_req[1] code 3'b010 at t, again at t+1 with code 3'b111 -> lost=1 at t+2, exc_code=2. Ack with no overrun -> lost=0.
5. Ack-cycle re-arm: src_req[0] code 3'b011 coincident with ack of idx 0 -> pend[0]=1 and lost=0. Idx 0 re-presented with code 3 at a+3.
6. EXC_MASK_EN: pend=4'b0011, src_mask=4'b0001 -> idx 1 presented first. Unmask, ack -> idx 0 presented at a+3.
